// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle RV64I subset controller driving the 64-bit datapath control inputs
module control_unit #(
  parameter int unsigned     WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [WORDSIZE-1:0] pc,
  input  logic                alu_zero,
  output logic [4:0]          rf_addr_a,
  output logic [4:0]          rf_addr_b,
  output logic [4:0]          rf_write_addr,
  output logic                rf_write_en,
  output logic [WORDSIZE-1:0] immediate,
  output logic                mux_0_sel,
  output logic                mux_1_sel,
  output logic                mux_2_sel,
  output logic [2:0]          alu_operation,
  output logic                dm_write_en,
  output logic                illegal_instr
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;
  typedef enum logic [2:0] {K_ILL, K_R, K_ADDI, K_LD, K_SD, K_BEQ} kind_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  state_t              state, state_next;
  kind_t               kind;
  logic [31:0]         ir;
  logic                ir_load;
  logic [WORDSIZE-1:0] pc_next, pc_plus4;
  logic [6:0]          opcode, funct7;
  logic [2:0]          funct3;

  // All decode is combinational from the latched word, so outputs hold until the next accept.
  assign opcode        = ir[6:0];
  assign funct3        = ir[14:12];
  assign funct7        = ir[31:25];
  assign rf_addr_a     = ir[19:15];
  assign rf_addr_b     = ir[24:20];
  assign rf_write_addr = ir[11:7];
  assign mux_0_sel     = 1'b0;
  assign pc_plus4      = pc + WORDSIZE'(4);

  always_comb begin
    kind          = K_ILL;
    alu_operation = OP_ADD;
    mux_1_sel     = 1'b0;
    mux_2_sel     = 1'b0;
    immediate     = {{(WORDSIZE-12){ir[31]}}, ir[31:20]};
    case (opcode)
      7'b0110011: begin
        mux_1_sel = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) kind = K_R;
            else if (funct7 == 7'b0100000) begin
              kind          = K_R;
              alu_operation = OP_SUB;
            end
          end
          3'b111: if (funct7 == 7'b0000000) begin kind = K_R; alu_operation = OP_AND; end
          3'b110: if (funct7 == 7'b0000000) begin kind = K_R; alu_operation = OP_OR;  end
          3'b100: if (funct7 == 7'b0000000) begin kind = K_R; alu_operation = OP_XOR; end
          default: kind = K_ILL;
        endcase
        if (kind == K_ILL) mux_1_sel = 1'b0;
      end
      7'b0010011: if (funct3 == 3'b000) kind = K_ADDI;
      7'b0000011: if (funct3 == 3'b011) begin kind = K_LD; mux_2_sel = 1'b1; end
      7'b0100011: begin
        immediate = {{(WORDSIZE-12){ir[31]}}, ir[31:25], ir[11:7]};
        if (funct3 == 3'b011) kind = K_SD;
      end
      7'b1100011: begin
        immediate = {{(WORDSIZE-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        if (funct3 == 3'b000) begin
          kind          = K_BEQ;
          alu_operation = OP_SUB;
          mux_1_sel     = 1'b1;
        end
      end
      default: kind = K_ILL;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    case (state)
      FETCH: begin
        if (instr_valid) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (kind == K_ILL) begin
          state_next = FETCH;
          pc_next    = pc_plus4;
        end else begin
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        case (kind)
          K_LD, K_SD: state_next = MEMORY;
          K_BEQ: begin
            state_next = FETCH;
            pc_next    = alu_zero ? pc + immediate : pc_plus4;
          end
          default: state_next = WRITEBACK;
        endcase
      end
      MEMORY: begin
        if (kind == K_LD) begin
          state_next = WRITEBACK;
        end else begin
          state_next = FETCH;
          pc_next    = pc_plus4;
        end
      end
      WRITEBACK: begin
        state_next = FETCH;
        pc_next    = pc_plus4;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= instr;
    end
  end

  assign instr_ready   = !rst && (state == FETCH);
  assign rf_write_en   = !rst && (state == WRITEBACK) && (ir[11:7] != 5'd0);
  assign dm_write_en   = !rst && (state == MEMORY) && (kind == K_SD);
  assign illegal_instr = !rst && (state == DECODE) && (kind == K_ILL);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] pc;
  logic        alu_zero;
  logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr;
  logic        rf_write_en;
  logic [63:0] immediate;
  logic        mux_0_sel, mux_1_sel, mux_2_sel;
  logic [2:0]  alu_operation;
  logic        dm_write_en;
  logic        illegal_instr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  d_a, d_b, d_wa;
  logic [63:0] d_imm;
  logic        d_m1, d_m2;
  logic [2:0]  d_op;
  logic [7:0]  we_mask, dm_mask, il_mask;
  int          cycles;

  control_unit #(.WORDSIZE(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .alu_zero(alu_zero),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_write_addr(rf_write_addr),
    .rf_write_en(rf_write_en), .immediate(immediate), .mux_0_sel(mux_0_sel),
    .mux_1_sel(mux_1_sel), .mux_2_sel(mux_2_sel), .alu_operation(alu_operation),
    .dm_write_en(dm_write_en), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one instruction, capture DECODE-cycle outputs, then record strobes per cycle until ready.
  task automatic run(input logic [31:0] w, input logic az);
    logic done;
    instr       = w;
    instr_valid = 1'b1;
    alu_zero    = az;
    tick();
    instr_valid = 1'b0;
    d_a = rf_addr_a; d_b = rf_addr_b; d_wa = rf_write_addr; d_imm = immediate;
    d_m1 = mux_1_sel; d_m2 = mux_2_sel; d_op = alu_operation;
    we_mask = '0; dm_mask = '0; il_mask = '0; cycles = 0; done = 1'b0;
    for (int c = 1; c < 8; c++) begin
      if (!done) begin
        if (instr_ready) begin
          cycles = c;
          done   = 1'b1;
        end else begin
          we_mask[c] = rf_write_en;
          dm_mask[c] = dm_write_en;
          il_mask[c] = illegal_instr;
          tick();
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; alu_zero = 1'b0;
    tick();
    chk("rst_ready", instr_ready, 0);
    chk("rst_we", rf_write_en, 0);
    chk("rst_pc", pc, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", instr_ready, 1);
    chk("imm_after_rst", immediate, 0);

    run(32'h00500093, 1'b0);
    chk("addi_a", d_a, 0);
    chk("addi_imm", d_imm, 5);
    chk("addi_m1", d_m1, 0);
    chk("addi_op", d_op, 3'b000);
    chk("addi_wa", d_wa, 1);
    chk("addi_we_mask", we_mask, 8'b0000_1000);
    chk("addi_cycles", cycles, 4);
    chk("addi_pc", pc, 4);
    chk("mux0", mux_0_sel, 0);

    run(32'h402081B3, 1'b0);
    chk("sub_a", d_a, 1);
    chk("sub_b", d_b, 2);
    chk("sub_op", d_op, 3'b001);
    chk("sub_m1", d_m1, 1);
    chk("sub_wa", d_wa, 3);
    chk("sub_we_mask", we_mask, 8'b0000_1000);
    chk("sub_pc", pc, 8);

    run(32'h00208863, 1'b0);
    chk("beq_nt_imm", d_imm, 16);
    chk("beq_nt_op", d_op, 3'b001);
    chk("beq_nt_m1", d_m1, 1);
    chk("beq_nt_we", we_mask, 0);
    chk("beq_nt_dm", dm_mask, 0);
    chk("beq_nt_cycles", cycles, 3);
    chk("beq_nt_pc", pc, 12);

    run(32'h00208863, 1'b1);
    chk("beq_t_we", we_mask, 0);
    chk("beq_t_dm", dm_mask, 0);
    chk("beq_t_pc", pc, 28);

    run(32'h00813283, 1'b0);
    chk("ld_imm", d_imm, 8);
    chk("ld_m2", d_m2, 1);
    chk("ld_m1", d_m1, 0);
    chk("ld_wa", d_wa, 5);
    chk("ld_we_mask", we_mask, 8'b0001_0000);
    chk("ld_dm", dm_mask, 0);
    chk("ld_cycles", cycles, 5);
    chk("ld_pc", pc, 32);

    run(32'hFE513C23, 1'b0);
    chk("sd_imm", d_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("sd_a", d_a, 2);
    chk("sd_b", d_b, 5);
    chk("sd_op", d_op, 3'b000);
    chk("sd_dm_mask", dm_mask, 8'b0000_1000);
    chk("sd_we", we_mask, 0);
    chk("sd_cycles", cycles, 4);
    chk("sd_pc", pc, 36);

    run(32'hFFFFFFFF, 1'b0);
    chk("ill_mask", il_mask, 8'b0000_0010);
    chk("ill_we", we_mask, 0);
    chk("ill_dm", dm_mask, 0);
    chk("ill_cycles", cycles, 2);
    chk("ill_pc", pc, 40);

    run(32'h00100013, 1'b0);
    chk("x0_we", we_mask, 0);
    chk("x0_cycles", cycles, 4);
    chk("x0_pc", pc, 44);

    // Abandon a load while it sits in MEMORY.
    instr = 32'h00813283; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("mid_no_ready", instr_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", rf_write_en, 0);
    chk("mid_rst_ready", instr_ready, 0);
    tick();
    chk("mid_rst_we2", rf_write_en, 0);
    rst = 1'b0;
    #1;
    chk("mid_ready", instr_ready, 1);
    chk("mid_pc", pc, 0);
    chk("mid_imm", immediate, 0);
    chk("mid_wa", rf_write_addr, 0);
    chk("mid_m2", mux_2_sel, 0);

    run(32'h00500093, 1'b0);
    chk("post_we_mask", we_mask, 8'b0000_1000);
    chk("post_wa", d_wa, 1);
    chk("post_pc", pc, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle controller that drives the 64-bit datapath's control inputs. It supplies register-file addresses and write enable, the immediate, the three mux selects, the ALU operation and the data-memory write enable.
- Accepts one 32-bit RV64I instruction at a time over a valid/ready handshake, decodes it, and sequences it through per-instruction states.
- Maintains the program counter and resolves beq using the datapath's ALU-zero indication.

Parameters:
- WORDSIZE, 64, datapath word width; sets immediate and pc width.
- RESET_PC, 0, pc value loaded on reset.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- instr  input  32  instruction word; sampled on handshake.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  controller is in FETCH and will accept an instruction.
- pc  output  WORDSIZE  address of the instruction to fetch / being executed.
- alu_zero  input  1  datapath ALU result == 0; sampled in EXECUTE.
- rf_addr_a  output  5  rs1.
- rf_addr_b  output  5  rs2.
- rf_write_addr  output  5  rd.
- rf_write_en  output  1  register-file write strobe.
- immediate  output  WORDSIZE  sign-extended immediate.
- mux_0_sel  output  1  ALU A source: 0=rf_data_a, 1=rf_data_b.
- mux_1_sel  output  1  ALU B source: 0=immediate, 1=rf_data_b.
- mux_2_sel  output  1  writeback source: 0=alu_result, 1=dm_data_output.
- alu_operation  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- dm_write_en  output  1  data-memory write strobe.
- illegal_instr  output  1  one-cycle pulse on unsupported encoding.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Reset:
  - On a clk edge with rst=1: state←FETCH, pc←RESET_PC, all latched fields and registered outputs←0.
  - While rst=1, instr_ready, rf_write_en, dm_write_en and illegal_instr are forced to 0 combinationally.
  - Reset mid-instruction abandons that instruction; no write strobe is issued.
- FETCH:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to DECODE.
  - instr_valid outside FETCH is ignored.
- DECODE: 1 cycle. Decode opcode/funct3/funct7 and form the immediate.
  - I-type: instr[31:20].
  - S-type: {instr[31:25],instr[11:7]}.
  - B-type: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
  - Sign-extend every immediate to WORDSIZE.
  - Control outputs become valid in DECODE and stay stable until return to FETCH. The only exceptions are the strobes.
- Supported instructions and control settings (mux_0_sel=0 for all):
  - R-type (0110011), funct3=000/111/110/100: add/sub (funct7[5] picks SUB), and, or, xor. mux_1=1, mux_2=0.
  - addi (0010011, funct3=000): ADD, mux_1=0, mux_2=0.
  - ld (0000011, funct3=011): ADD, mux_1=0, mux_2=1.
  - sd (0100011, funct3=011): ADD, mux_1=0; store data is taken from rf_addr_b.
  - beq (1100011, funct3=000): SUB, mux_1=1.
- Sequences (cycles counted from the accept edge):
  - R/addi: DECODE→EXECUTE→WRITEBACK→FETCH.
  - ld: DECODE→EXECUTE→MEMORY→WRITEBACK→FETCH.
  - sd: DECODE→EXECUTE→MEMORY→FETCH.
  - beq: DECODE→EXECUTE→FETCH.
- Strobes:
  - rf_write_en=1 for exactly the WRITEBACK cycle, and only if rd≠0.
  - dm_write_en=1 for exactly the sd MEMORY cycle.
  - No other strobes are issued.
- pc update, on the edge leaving the instruction's last state:
  - Non-branch instructions: pc←pc+4.
  - beq: alu_zero is sampled in EXECUTE; pc←pc+immediate if 1, else pc+4.
  - Arithmetic is modulo 2^WORDSIZE; wrap-around is permitted.
- Illegal encoding (any other opcode/funct combination):
  - illegal_instr=1 during DECODE; no strobes.
  - pc←pc+4 and return to FETCH on the next edge.
- Back-to-back: instr_valid held high lets the next instruction be accepted on the first FETCH cycle. There are no bubbles beyond the FETCH cycle.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) → DECODE: rf_addr_a=0, immediate=5, mux_1_sel=0, alu_operation=000; rf_write_en=1, rf_write_addr=1 only in the 3rd cycle after accept; pc 0→4.
- sub x3,x1,x2 (0x402081B3) → rf_addr_a=1, rf_addr_b=2, alu_operation=001, mux_1_sel=1; single rf_write_en to rd=3.
- ld x5,8(x2) (0x00813283) → immediate=8, mux_2_sel=1, rf_write_en in 4th cycle after accept. Then sd x5,-8(x2) (0xFE513C23) → immediate=0xFFFFFFFFFFFFFFF8, dm_write_en one cycle in MEMORY, rf_write_en never asserted.
- beq x1,x2,+16 (0x00208863) at pc=8 → alu_zero=1 gives pc=24; repeated with alu_zero=0 gives pc=12; no strobes in either case.
- 0xFFFFFFFF → illegal_instr one-cycle pulse, no strobes, pc+4. addi x0,x0,1 → rf_write_en stays 0.
- rst asserted during ld MEMORY state → no rf_write_en; next cycle state=FETCH, pc=RESET_PC, outputs 0; a following instruction executes normally.
